// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku game blocks: FSM encodings, BCD digit
// limits and the default elapsed-second prescaler divisor.
package sudoku_pkg;

    // Game timer state encodings; 2'd3 is unreachable and decodes as idle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // BCD digit limits.
    localparam logic [3:0] DIG_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Clock cycles per elapsed second at the board clock.
    localparam int unsigned TICK_DIV_DEFAULT = 50000000;
    localparam int unsigned CNT_W_DEFAULT    = 26;

    // True when the four digits read 99:59, the largest displayable time.
    function automatic logic is_time_max(input logic [3:0] min_tens,
                                         input logic [3:0] min_ones,
                                         input logic [3:0] sec_tens,
                                         input logic [3:0] sec_ones);
        return (min_tens == DIG_MAX) && (min_ones == DIG_MAX) &&
               (sec_tens == SEC_TENS_MAX) && (sec_ones == DIG_MAX);
    endfunction

endpackage

// File: rtl/game_timer_if.sv
// Signal bundle between the game control / display side and the game timer.
interface game_timer_if;

    logic       gameStart;
    logic [3:0] secOnes;
    logic [3:0] secTens;
    logic [3:0] minOnes;
    logic [3:0] minTens;
    logic       running;
    logic       frozen;
    logic       secTick;
    logic       timeMax;

    // Game control side: drives the start level, reads time and status.
    modport master (
        output gameStart,
        input  secOnes, secTens, minOnes, minTens,
        input  running, frozen, secTick, timeMax
    );

    // Timer side.
    modport slave (
        input  gameStart,
        output secOnes, secTens, minOnes, minTens,
        output running, frozen, secTick, timeMax
    );

endinterface

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit of the elapsed-time counter. Wraps to zero past 'limit'
// and reports a carry in the same cycle so a whole digit chain advances
// in one clock.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       carry
);

    logic at_limit;

    assign at_limit = (value == limit);
    assign carry    = inc && at_limit;

    // Digit register: clear has priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= at_limit ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/game_timer.sv
// Sudoku elapsed-time counter. Counts MM:SS in BCD while gameStart is
// high, holds the time when gameStart falls and restarts from 00:00 on the
// next start. Saturates at 99:59.
module game_timer
    import sudoku_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    game_timer_if.slave   bus
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] presc;
    logic             sec_tick;

    logic             start;
    logic             st_run;
    logic             st_done;
    logic             st_idle;
    logic             restart;
    logic             tick_due;
    logic             at_max;
    logic             advance;

    logic [3:0]       sec_ones;
    logic [3:0]       sec_tens;
    logic [3:0]       min_ones;
    logic [3:0]       min_tens;
    logic             so_carry;
    logic             st_carry;
    logic             mo_carry;
    logic             mt_carry;

    assign start   = bus.gameStart;
    assign st_run  = (state == ST_RUN);
    assign st_done = (state == ST_DONE);
    assign st_idle = !st_run && !st_done;

    // Starting from idle or restarting after a win both begin at 00:00.
    assign restart  = start && (st_idle || st_done);
    // A tick only counts while the game is still in progress this cycle.
    assign tick_due = st_run && start && (presc == TICK_LAST);
    assign at_max   = is_time_max(min_tens, min_ones, sec_tens, sec_ones);
    assign advance  = tick_due && !at_max;

    // Game state machine; the unused encoding falls back to idle behaviour.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_RUN:  if (!start) state <= ST_DONE;
                ST_DONE: if (start)  state <= ST_RUN;
                default: state <= start ? ST_RUN : ST_IDLE;
            endcase
        end
    end

    // Seconds prescaler: runs only while playing, holds when frozen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (restart) begin
            presc <= '0;
        end else if (st_run && start) begin
            presc <= tick_due ? '0 : presc + 1'b1;
        end
    end

    // Registered so the pulse lines up with the new digit value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= advance;
        end
    end

    bcd_digit u_sec_ones (
        .clk   (CLK),
        .rst   (RST),
        .clear (restart),
        .inc   (advance),
        .limit (DIG_MAX),
        .value (sec_ones),
        .carry (so_carry)
    );

    bcd_digit u_sec_tens (
        .clk   (CLK),
        .rst   (RST),
        .clear (restart),
        .inc   (so_carry),
        .limit (SEC_TENS_MAX),
        .value (sec_tens),
        .carry (st_carry)
    );

    bcd_digit u_min_ones (
        .clk   (CLK),
        .rst   (RST),
        .clear (restart),
        .inc   (st_carry),
        .limit (DIG_MAX),
        .value (min_ones),
        .carry (mo_carry)
    );

    bcd_digit u_min_tens (
        .clk   (CLK),
        .rst   (RST),
        .clear (restart),
        .inc   (mo_carry),
        .limit (DIG_MAX),
        .value (min_tens),
        .carry (mt_carry)
    );

    // Saturation gating means the top digit can never wrap.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!mt_carry) else $error("minutes tens wrapped past 99:59");
        end
    end

    assign bus.secOnes = sec_ones;
    assign bus.secTens = sec_tens;
    assign bus.minOnes = min_ones;
    assign bus.minTens = min_tens;
    assign bus.running = st_run;
    assign bus.frozen  = st_done;
    assign bus.secTick = sec_tick;
    assign bus.timeMax = at_max;

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Elapsed-time counter for a Sudoku game; consumes the level-type gameStart qualifier from the game-start logic.
- Counts MM:SS in BCD while gameStart is high, freezes the display when gameStart falls (win), and restarts from 00:00 on the next start.
- BCD digit outputs feed the seven-segment display driver; status flags feed the top-level game control.

Parameters:
- TICK_DIV, 50000000, CLK cycles per elapsed second; must be >= 2. Benches use 4.
- CNT_W, 26, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- gameStart  input  1  level; high = game in progress, low = idle or won.
- secOnes  output  4  BCD seconds units, 0-9.
- secTens  output  4  BCD seconds tens, 0-5.
- minOnes  output  4  BCD minutes units, 0-9.
- minTens  output  4  BCD minutes tens, 0-9.
- running  output  1  high while in RUN state.
- frozen  output  1  high while in DONE state (time held after win).
- secTick  output  1  one-cycle pulse in the cycle the seconds value increments.
- timeMax  output  1  high while the count is saturated at 99:59.

Behaviour:
- Reset (asynchronous): state=IDLE; all digits 0; prescaler 0; running=0, frozen=0, secTick=0, timeMax=0.
- States:
  - IDLE: the digits hold 00:00. If gameStart is sampled high, go to RUN on the next edge, and clear the prescaler.
  - RUN: the prescaler increments each cycle. When prescaler == TICK_DIV-1: prescaler <= 0, the time advances by one second, and secTick=1 for that cycle. If gameStart is sampled low, go to DONE on the next edge; there is no increment in that cycle, even if a tick is due.
  - DONE: the digits and prescaler hold. If gameStart is sampled high, clear all digits and the prescaler and go to RUN (restart from 00:00).
- First increment: TICK_DIV cycles after entering RUN. secTick is registered, so it is asserted in the same cycle the new digit value appears.
- BCD carry chain, all in one cycle:
  - secOnes 9->0 carries into secTens.
  - secTens 5->0 carries into minOnes.
  - minOnes 9->0 carries into minTens.
- Saturation: at 99:59, further ticks do not change the digits and secTick stays 0. timeMax=1 from the cycle 99:59 appears until the digits are cleared. The prescaler keeps wrapping.
- running = (state==RUN). frozen = (state==DONE). Both are decoded from registered state, with no combinational path from gameStart.
- gameStart is used only as a sampled level; no edge detector is required beyond the state machine.
- Glitches on gameStart shorter than one cycle are not tracked; the block acts on whatever value is sampled at each edge.
- RST asserted mid-count returns to IDLE with 00:00 immediately, without waiting for a clock edge. After RST deasserts, a high gameStart enters RUN on the next edge.
- Digits never hold non-BCD values. secTens never exceeds 5.

Decomposition:
- Shared package (sudoku_pkg) holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is unreachable and decodes to IDLE);
  - BCD limits DIG_MAX=4'd9 and SEC_TENS_MAX=4'd5;
  - the default TICK_DIV.
- One sub-module, bcd_digit, instantiated 4 times:
  - inputs: clear, inc, limit;
  - outputs: 4-bit value and carry = inc && value==limit.
- The top level holds the FSM, the prescaler, the saturation check and the secTick register.

Test Plan:
- Reset, then gameStart=1 with TICK_DIV=4 -> running=1 one edge later; secOnes=1 exactly 4 cycles after entering RUN; secTick pulses once every 4 cycles.
- Run to 00:59 then one more tick -> digits read 01:00 in the same cycle; secTick=1 that cycle.
- Drop gameStart at 00:07 -> frozen=1, running=0; digits hold 00:07 for 20+ cycles; raise gameStart -> 00:00 and RUN, with the first tick 4 cycles later.
- Force a run to 99:59 (long run or time-accelerated bench) -> timeMax=1; the next ticks leave 99:59 unchanged and secTick stays 0.
- Assert RST mid-cycle at 03:42 between clock edges -> all outputs 0 immediately, before the next edge; state IDLE.
- gameStart falls in the exact cycle prescaler==TICK_DIV-1 at 00:05 -> no increment; frozen shows 00:05.
